// File: rtl/multi_port_memory_model.sv
// Multi-port behavioural memory: a round-robin arbiter admits one request at a time
// and answers it a fixed number of cycles later. A write to the done address raises a sticky flag.
module multi_port_memory_model #(
  parameter int unsigned num_ports_p   = 2,
  parameter int unsigned words_p       = 2048,
  parameter int unsigned width_words_p = 4,
  parameter int unsigned delay_p       = 5,
  parameter logic [31:0] done_addr_p   = 32'h0000_1FFC
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [num_ports_p-1:0]                      valid_i,
  output logic [num_ports_p-1:0]                      ready_o,
  input  logic [num_ports_p-1:0]                      we_i,
  input  logic [num_ports_p-1:0][31:0]                addr_i,
  input  logic [num_ports_p-1:0][width_words_p*32-1:0] wdata_i,
  output logic [num_ports_p-1:0]                      valid_o,
  output logic [num_ports_p-1:0][width_words_p*32-1:0] data_o,
  output logic                                        done_o,
  output logic [31:0]                                 done_data_o
);

  localparam int unsigned port_w_lp    = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
  localparam int unsigned blk_w_lp     = $clog2(width_words_p);
  localparam int unsigned blocks_lp    = words_p / width_words_p;
  localparam int unsigned blk_idx_w_lp = (blocks_lp > 1) ? $clog2(blocks_lp) : 1;
  localparam int unsigned cnt_w_lp     = (delay_p > 1) ? $clog2(delay_p) : 1;
  localparam int unsigned blk_bits_lp  = width_words_p * 32;
  localparam logic [31:0] blk_mask_lp  = ~(32'(width_words_p * 4) - 32'd1);

  typedef logic [port_w_lp-1:0]    port_t;
  typedef logic [blk_bits_lp-1:0]  block_t;
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  r_state, w_next_state;
  logic [cnt_w_lp-1:0]     r_cnt;
  port_t                   r_last;
  port_t                   r_port;
  logic                    r_we;
  block_t                  r_rdata;
  logic [num_ports_p-1:0][blk_bits_lp-1:0] r_hold;
  logic                    r_done;
  logic [31:0]             r_done_data;

  logic                    w_grant_vld;
  port_t                   w_grant;
  logic                    w_accept;
  logic                    w_resp;
  logic                    w_req_we;
  logic [31:0]             w_req_addr;
  logic [blk_idx_w_lp-1:0] w_idx;
  logic                    w_done_hit;

  // Memory is stored one transfer block per entry since every access is a whole block.
  // The 2-state type makes every entry start at zero at time zero, independent of reset.
  bit [blk_bits_lp-1:0] r_mem [blocks_lp];

  // Round-robin search starting one past the most recently granted port.
  always_comb begin
    logic [31:0] idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = '0;
    for (int i = 1; i <= int'(num_ports_p); i++) begin
      idx = (32'(r_last) + 32'(i)) % 32'(num_ports_p);
      if (!w_grant_vld && valid_i[port_t'(idx)]) begin
        w_grant_vld = 1'b1;
        w_grant     = port_t'(idx);
      end
    end
  end

  assign w_req_we   = we_i[w_grant];
  assign w_req_addr = addr_i[w_grant];
  assign w_idx      = w_req_addr[2 + blk_w_lp +: blk_idx_w_lp];
  assign w_done_hit = (w_req_addr & blk_mask_lp) == (done_addr_p & blk_mask_lp);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours, exactly like real flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    ready_o      = '0;
    valid_o      = '0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!reset_i && w_grant_vld) begin
          ready_o[w_grant] = 1'b1;
          w_accept         = 1'b1;
          w_next_state     = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          if (!reset_i) valid_o[r_port] = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_resp = |valid_o;

  // NOTE: the memory has no reset branch on purpose: contents must survive reset_i,
  // and a reset-free array is what maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_accept && w_req_we) r_mem[w_idx] <= wdata_i[w_grant];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt       <= '0;
      r_last      <= port_t'(num_ports_p - 1);
      r_port      <= '0;
      r_we        <= 1'b0;
      r_rdata     <= '0;
      r_hold      <= '0;
      r_done      <= 1'b0;
      r_done_data <= '0;
    end else begin
      if (w_accept) begin
        r_cnt  <= cnt_w_lp'(delay_p - 1);
        r_port <= w_grant;
        r_last <= w_grant;
        r_we   <= w_req_we;
        // Reads sample the array at acceptance, so earlier accepted writes are visible.
        if (!w_req_we) r_rdata <= r_mem[w_idx];
        if (w_req_we && w_done_hit && !r_done) begin
          r_done      <= 1'b1;
          r_done_data <= wdata_i[w_grant][31:0];
        end
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_resp && !r_we) r_hold[r_port] <= r_rdata;
    end
  end

  // The read block appears in the response cycle itself, then lives on in r_hold.
  always_comb begin
    data_o = r_hold;
    if (w_resp && !r_we) data_o[r_port] = r_rdata;
  end

  assign done_o      = r_done;
  assign done_data_o = r_done_data;

endmodule

// File: tb/tb_multi_port_memory_model.sv
// Randomized bench for multi_port_memory_model: a driver with a block-level reference model
// pushes expected responses; a monitor pops and compares whenever the DUT responds.
module tb_multi_port_memory_model;

  localparam int          N         = 2;
  localparam int          WORDS     = 2048;
  localparam int          WW        = 4;
  localparam int          DLY       = 5;
  localparam logic [31:0] DONE_ADDR = 32'h0000_1FFC;
  localparam int          BW        = WW * 32;

  typedef logic [BW-1:0] blk_t;
  typedef struct {
    int   port;
    bit   we;
    blk_t data;
    int   due;
  } resp_t;

  logic                  clk = 1'b0;
  logic                  reset_i = 1'b1;
  logic [N-1:0]          valid_i = '0;
  logic [N-1:0]          ready_o;
  logic [N-1:0]          we_i = '0;
  logic [N-1:0][31:0]    addr_i = '0;
  logic [N-1:0][BW-1:0]  wdata_i = '0;
  logic [N-1:0]          valid_o;
  logic [N-1:0][BW-1:0]  data_o;
  logic                  done_o;
  logic [31:0]           done_data_o;

  multi_port_memory_model #(
    .num_ports_p  (N),
    .words_p      (WORDS),
    .width_words_p(WW),
    .delay_p      (DLY),
    .done_addr_p  (DONE_ADDR)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .done_o     (done_o),
    .done_data_o(done_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Requests presented by each port (held until the model grants them).
  bit          rst_req;
  bit          req_v     [N];
  bit          req_we    [N];
  logic [31:0] req_addr  [N];
  blk_t        req_wdata [N];

  // Reference model state.
  blk_t        mdl_mem [int];
  int          last_port;
  int          next_free;
  bit          done_set;
  int          done_cycle;
  logic [31:0] done_word;
  blk_t        exp_hold [N];
  resp_t       sb [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int blk_of(input logic [31:0] a);
    return int'(((a >> 2) % WORDS) / WW);
  endfunction

  function automatic bit done_hit(input logic [31:0] a);
    logic [31:0] mask;
    mask = ~(32'(WW * 4) - 32'd1);
    return (a & mask) == (DONE_ADDR & mask);
  endfunction

  function automatic void model_reset();
    sb.delete();
    last_port = N - 1;
    next_free = 0;
    done_set  = 1'b0;
    for (int p = 0; p < N; p++) exp_hold[p] = '0;
  endfunction

  // Port expected to win this cycle, or -1 when none may be granted.
  function automatic int exp_grant();
    int p;
    if (rst_req || cyc < next_free) return -1;
    for (int i = 1; i <= N; i++) begin
      p = (last_port + i) % N;
      if (req_v[p]) return p;
    end
    return -1;
  endfunction

  function automatic void model_accept(input int p);
    resp_t r;
    int    b;
    b      = blk_of(req_addr[p]);
    r.port = p;
    r.we   = req_we[p];
    r.due  = cyc + DLY;
    r.data = '0;
    if (req_we[p]) begin
      mdl_mem[b] = req_wdata[p];
      if (done_hit(req_addr[p]) && !done_set) begin
        done_set   = 1'b1;
        done_cycle = cyc;
        done_word  = req_wdata[p][31:0];
      end
    end else begin
      r.data = mdl_mem.exists(b) ? mdl_mem[b] : '0;
    end
    sb.push_back(r);
    last_port = p;
    next_free = cyc + DLY + 1;
  endfunction

  task automatic cycle_step();
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset_i = rst_req;
    for (int p = 0; p < N; p++) begin
      valid_i[p] = req_v[p];
      we_i[p]    = req_we[p];
      addr_i[p]  = req_addr[p];
      wdata_i[p] = req_wdata[p];
    end
    if (rst_req) model_reset();
    #1;
    g       = exp_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready_o", ready_o, exp_rdy);
    if (g >= 0) begin
      model_accept(g);
      req_v[g] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_step();
  endtask

  task automatic issue(input int p, input bit we, input logic [31:0] a, input blk_t d);
    int n;
    n            = 0;
    req_v[p]     = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_wdata[p] = d;
    while (req_v[p] && n < 40) begin
      cycle_step();
      n++;
    end
    if (req_v[p]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout port=%0d addr=%h not granted within 40 cycles", p, a);
      req_v[p] = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] off;
    off = 32'($urandom_range(0, 15));
    case ($urandom_range(0, 5))
      0:       return 32'h1FF0 + off;
      1:       return 32'h3FF0 + off;
      2:       return 32'h2000 + 32'($urandom_range(0, 15)) * 16 + off;
      default: return 32'($urandom_range(0, 15)) * 16 + off;
    endcase
  endfunction

  function automatic void rand_req(input int p);
    req_v[p]     = 1'b1;
    req_we[p]    = 1'($urandom_range(0, 1));
    req_addr[p]  = rand_addr();
    req_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares every response and the sticky done outputs.
  initial begin
    resp_t        e;
    logic [N-1:0] exp_v;
    bit           dvis;
    forever begin
      @(negedge clk);
      #2;
      if (reset_i) begin
        check("valid_o_in_reset", valid_o, '0);
        continue;
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_response port=%0d: got no valid_o by cycle %0d expected at %0d",
                 e.port, cyc, e.due);
      end
      if (valid_o != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid at cycle %0d: got valid_o=%b expected none", cyc, valid_o);
        end else begin
          e          = sb.pop_front();
          exp_v      = '0;
          exp_v[e.port] = 1'b1;
          check("valid_o_port", valid_o, exp_v);
          check("response_cycle", cyc, e.due);
          if (e.we) begin
            check("data_o_after_write", data_o[e.port], exp_hold[e.port]);
          end else begin
            check("read_data", data_o[e.port], e.data);
            exp_hold[e.port] = e.data;
          end
        end
      end else begin
        for (int p = 0; p < N; p++) check("data_o_hold", data_o[p], exp_hold[p]);
      end
      dvis = done_set && (cyc > done_cycle);
      check("done_o", done_o, dvis);
      check("done_data_o", done_data_o, dvis ? done_word : 32'h0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < N; p++) begin
      req_v[p]     = 1'b0;
      req_we[p]    = 1'b0;
      req_addr[p]  = '0;
      req_wdata[p] = '0;
    end
    model_reset();
    rst_req = 1'b1;
    idle(3);
    rst_req = 1'b0;

    // Write then read back the same block, sub-block offset and an aliased address.
    issue(0, 1'b1, 32'h0000_0100, {32'd4, 32'd3, 32'd2, 32'd1});
    issue(0, 1'b0, 32'h0000_0100, '0);
    issue(1, 1'b0, 32'h0000_010C, '0);
    issue(0, 1'b0, 32'h0000_2100, '0);
    idle(DLY + 1);

    // Both ports saturated with reads straight out of reset: strict alternation.
    rst_req = 1'b1;
    idle(2);
    rst_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!req_v[p]) begin
          req_v[p]    = 1'b1;
          req_we[p]   = 1'b0;
          req_addr[p] = rand_addr();
        end
      end
      cycle_step();
    end
    for (int p = 0; p < N; p++) req_v[p] = 1'b0;
    idle(DLY + 1);

    // Completion flag: first matching write sets it, later ones leave the data alone.
    issue(1, 1'b1, 32'h0000_1FFC, {96'h0, 32'h0000_CAFE});
    issue(0, 1'b1, 32'h0000_1FF0, {96'h0, 32'h0000_BEEF});
    issue(1, 1'b1, 32'h0000_3FFC, {96'h0, 32'h0000_1234});
    idle(DLY + 1);
    check("done_data_sticky", done_data_o, 32'h0000_CAFE);

    // Reset two cycles after a read accept aborts the response; memory survives.
    issue(0, 1'b0, 32'h0000_1FFC, '0);
    idle(1);
    rst_req = 1'b1;
    idle(1);
    rst_req = 1'b0;
    issue(1, 1'b0, 32'h0000_1FF8, '0);
    idle(DLY + 1);
    check("done_after_reset", done_o, 1'b0);

    // Randomized traffic, including waiting ports that withdraw or change requests.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!req_v[p]) begin
          if ($urandom_range(0, 1) == 1) rand_req(p);
        end else if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 1) rand_req(p);
          else req_v[p] = 1'b0;
        end
      end
      cycle_step();
    end
    for (int p = 0; p < N; p++) req_v[p] = 1'b0;
    idle(DLY + 3);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_port_memory_model.md
MULTI_PORT_MEMORY_MODEL -- requirements
Module: multi_port_memory_model

Interface
REQ-001 SHALL have parameter num_ports_p, default 2: number of independent request/response ports.
REQ-002 SHALL have parameter words_p, default 2048: memory depth in 32-bit words; power of two.
REQ-003 SHALL have parameter width_words_p, default 4: words per transfer; power of two, divides words_p.
REQ-004 SHALL have parameter delay_p, default 5: accept-to-response latency in cycles; legal range >=1.
REQ-005 SHALL have parameter done_addr_p, default 32'h0000_1FFC: byte address whose write flags test completion.
REQ-006 SHALL have ports clk_i (input, 1, the single clock) and reset_i (input, 1, synchronous active-high reset).
REQ-007 SHALL have port valid_i (input, num_ports_p, per-port request valid).
REQ-008 SHALL have port ready_o (input-side handshake, output, num_ports_p, per-port grant/ready).
REQ-009 SHALL have port we_i (input, num_ports_p, 1 = write, 0 = read).
REQ-010 SHALL have port addr_i (input, num_ports_p x 32, byte address per port).
REQ-011 SHALL have port wdata_i (input, num_ports_p x width_words_p*32, write data; word 0 in LSBs).
REQ-012 SHALL have port valid_o (output, num_ports_p, one-cycle response pulse per port).
REQ-013 SHALL have port data_o (output, num_ports_p x width_words_p*32, read data, held until next response on that port).
REQ-014 SHALL have ports done_o (output, 1, sticky completion flag) and done_data_o (output, 32, word 0 of the completing write).

Function
REQ-015 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-016 In IDLE, ready_o SHALL be one-hot at the round-robin winner among ports with valid_i=1, all-zero if no valid_i.
REQ-017 Round-robin: priority search starts at (last granted port + 1) mod num_ports_p; after reset, last granted = num_ports_p-1 (port 0 highest).
REQ-018 Accept = valid_i[p] & ready_o[p] in cycle t; IDLE -> BUSY; latch port id, we, address, wdata; down-counter loaded with delay_p-1.
REQ-019 In BUSY, ready_o SHALL be all-zero; counter decrements each cycle.
REQ-020 When counter is 0 in BUSY (cycle t+delay_p), valid_o[latched port] SHALL be 1 for exactly one cycle; FSM -> IDLE; next accept earliest at t+delay_p+1.
REQ-021 Word index = (addr_i >> 2) modulo words_p, rounded down to a multiple of width_words_p; addr_i[1:0] and sub-block bits ignored.
REQ-022 Writes SHALL commit all width_words_p words at acceptance cycle; reads SHALL sample memory at acceptance cycle (read after a same-port or other-port write accepted earlier sees new data).
REQ-023 For writes, valid_o still pulses at t+delay_p; data_o on that port SHALL be unchanged by a write.
REQ-024 For reads, data_o[p] SHALL update to the sampled block in the valid_o cycle and hold until the next read response to p.
REQ-025 Accepted write whose block-aligned byte address equals done_addr_p aligned likewise SHALL set done_o=1 and done_data_o=wdata word 0 from cycle t+1; done_o stays 1 until reset; later matching writes do not update done_data_o.
REQ-026 valid_i deasserted or changed by a non-granted port SHALL have no effect; non-granted requests wait without loss.
REQ-027 Memory contents SHALL initialise to zero at time zero only; reset does not clear memory.

Reset
REQ-028 While reset_i=1 at a clock edge: FSM -> IDLE, counter 0, valid_o=0, data_o=0, done_o=0, done_data_o=0, round-robin pointer to reset value.
REQ-029 Reset asserted in BUSY SHALL abort the pending response (no valid_o pulse); a write already committed remains in memory.
REQ-030 ready_o SHALL be all-zero during any cycle reset_i=1.

Verification
REQ-031 Port 0 write 0x100 data {4,3,2,1}, then read 0x100 (delay_p=5) -> valid_o[0] pulses 5 cycles after each accept; read data_o[0]={4,3,2,1}.
REQ-032 Both ports valid reads from reset -> port 0 granted first, port 1 accepted at t+6, port 0 (still valid) accepted after; strict alternation under saturation.
REQ-033 Read 0x10C after writing 0x100 -> same block returned; read addr 0x2100 (words_p=2048) -> aliases to 0x100.
REQ-034 Write 0x1FFC with word 0 = 0xCAFE -> done_o=1, done_data_o=0xCAFE next cycle; second write 0xBEEF -> done_data_o stays 0xCAFE.
REQ-035 Reset pulsed 2 cycles after a read accept -> no valid_o pulse, done_o=0, next request accepted in first cycle after reset deasserts.
REQ-036 delay_p=1 -> valid_o one cycle after accept; back-to-back requests accepted every 2 cycles.
